// File: rtl/qsystop_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// Ports: address, chipselect, write_n, writedata (master->slave); readdata (slave->master).
interface qsystop_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/qsystop_pio_in_edge.sv
// Input PIO: pin sync, per-bit debounce, edge capture (W1C), maskable level irq.
// Ports: clk, reset_n (async low), bus (Avalon-MM slave), in_port (pins), irq.
module qsystop_pio_in_edge #(
    parameter int DATA_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_EN          = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    qsystop_pio_in_edge_if.slave  bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    localparam int CW     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SET_MAX = SW'(SETTLE);

    typedef logic [DATA_WIDTH-1:0] dvec_t;

    dvec_t           sync_q [SYNC_STAGES];
    dvec_t           filt_q;
    dvec_t           prev_q;
    dvec_t           mask_q;
    dvec_t           ecap_q;
    dvec_t           evt;
    dvec_t           clr;
    dvec_t           sync_w;
    logic [CW-1:0]   cnt_q [DATA_WIDTH];
    logic [SW-1:0]   settle_q;
    logic            primed_q;
    logic            wr;
    logic [31:0]     rd_mux;
    logic            unused_wd;

    assign sync_w    = sync_q[SYNC_STAGES-1];
    assign wr        = bus.chipselect && !bus.write_n;
    assign unused_wd = ^bus.writedata;

    // Synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    // Per-bit debounce: filt follows sync only after a run of
    // DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < DATA_WIDTH; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (sync_w[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    filt_q[i] <= sync_w[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Capture stays disarmed until the reset zeros have flushed out of
    // the sync/debounce pipe, so pins idling high never look like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_q <= '0;
            primed_q <= 1'b0;
        end else if (!primed_q) begin
            if (settle_q == SET_MAX)
                primed_q <= 1'b1;
            else
                settle_q <= settle_q + 1'b1;
        end
    end

    always_comb begin
        evt = '0;
        if (primed_q) begin
            if (EDGE_TYPE == 0)
                evt = filt_q & ~prev_q;
            else if (EDGE_TYPE == 1)
                evt = ~filt_q & prev_q;
            else
                evt = filt_q ^ prev_q;
        end
    end

    always_comb begin
        clr = '0;
        if (wr && bus.address == 2'd3)
            clr = bus.writedata[DATA_WIDTH-1:0];
    end

    // Set beats clear when both hit the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            ecap_q <= '0;
        end else begin
            prev_q <= filt_q;
            ecap_q <= evt | (ecap_q & ~clr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mask_q <= '0;
        else if (IRQ_EN != 0 && wr && bus.address == 2'd2)
            mask_q <= bus.writedata[DATA_WIDTH-1:0];
    end

    assign irq = (IRQ_EN != 0) ? |(ecap_q & mask_q) : 1'b0;

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            2'd0:    rd_mux = 32'(filt_q);
            2'd2:    rd_mux = 32'(mask_q);
            2'd3:    rd_mux = 32'(ecap_q);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_mux;
    end
endmodule

// File: tb/tb_qsystop_pio_in_edge.sv
// Scoreboard bench for qsystop_pio_in_edge (SYNC=2, DEBOUNCE=4, rising edge).
// Stimulus pushes expectations; a monitor pops and compares after each sampled edge.
module tb_qsystop_pio_in_edge;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_port = 8'h00;
    logic       irq;
    logic       rd_req = 1'b0;
    logic       irq_req = 1'b0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    qsystop_pio_in_edge_if bus ();

    qsystop_pio_in_edge #(
        .DATA_WIDTH      (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (0),
        .IRQ_EN          (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Monitor: a request live at a posedge is answered just after it.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_req || irq_req) begin
                exp_t e;
                logic [31:0] act;
                #1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty actual=%0h required=entry", bus.readdata);
                end else begin
                    e = sb.pop_front();
                    act = e.is_irq ? {31'd0, irq} : bus.readdata;
                    if (act !== e.exp) begin
                        errors++;
                        $display("FAIL %s actual=%0h required=%0h", e.name, act, e.exp);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] x, input string nm);
        exp_t e;
        e.is_irq = 1'b0;
        e.exp    = x;
        e.name   = nm;
        sb.push_back(e);
        bus.address = a;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic irqchk(input logic x, input string nm);
        exp_t e;
        e.is_irq = 1'b1;
        e.exp    = {31'd0, x};
        e.name   = nm;
        sb.push_back(e);
        irq_req = 1'b1;
        @(negedge clk);
        irq_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state.
        cyc(3);
        reset_n = 1'b1;
        cyc(12);
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_ecap");
        rd(2'd1, 32'h0, "rsvd");
        irqchk(1'b0, "rst_irq");

        // Latency: filt updates at the 6th edge after the pin change.
        in_port = 8'h05;
        cyc(5);
        rd(2'd0, 32'h00, "data_edge6");
        rd(2'd0, 32'h05, "data_edge7");
        cyc(2);
        rd(2'd3, 32'h05, "ecap_05");
        wr(2'd1, 32'hFF);
        rd(2'd1, 32'h0, "rsvd_wr");
        wr(2'd3, 32'hFF);
        rd(2'd3, 32'h00, "ecap_clr");

        // Glitches of 1..3 cycles on bit1 are filtered out.
        for (int l = 1; l <= 3; l++) begin
            in_port = 8'h07;
            cyc(l);
            in_port = 8'h05;
            cyc(8);
        end
        rd(2'd0, 32'h05, "glitch_data");
        rd(2'd3, 32'h00, "glitch_ecap");

        // A 4-cycle pulse is just long enough to pass.
        in_port = 8'h07;
        cyc(4);
        in_port = 8'h05;
        cyc(10);
        rd(2'd3, 32'h02, "pulse4_ecap");
        rd(2'd0, 32'h05, "pulse4_data");
        wr(2'd3, 32'hFF);

        // Mask bit0, produce a rising edge on bit0.
        wr(2'd2, 32'h01);
        rd(2'd2, 32'h01, "mask_rd");
        irqchk(1'b0, "irq_idle");
        in_port = 8'h04;
        cyc(10);
        in_port = 8'h05;
        cyc(10);
        irqchk(1'b1, "irq_set");
        rd(2'd3, 32'h01, "ecap_b0");
        wr(2'd3, 32'h01);
        irqchk(1'b0, "irq_w1c");

        // Edge on bit2 lands the same cycle as its W1C.
        in_port = 8'h01;
        cyc(10);
        rd(2'd3, 32'h00, "ecap_fall");
        in_port = 8'h05;
        cyc(6);
        wr(2'd3, 32'h04);
        rd(2'd3, 32'h04, "set_wins");
        irqchk(1'b0, "irq_masked");
        wr(2'd2, 32'h04);
        irqchk(1'b1, "irq_unmask");
        wr(2'd3, 32'h04);
        rd(2'd3, 32'h00, "ecap_b2_clr");
        irqchk(1'b0, "irq_clr2");

        // Pins high through reset release: no capture.
        in_port = 8'hFF;
        cyc(2);
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(20);
        rd(2'd3, 32'h00, "hi_rst_ecap");
        irqchk(1'b0, "hi_rst_irq");
        rd(2'd0, 32'hFF, "hi_rst_data");
        rd(2'd2, 32'h00, "hi_rst_mask");

        cyc(3);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=done");
        $fatal(1);
    end
endmodule
